// File: rtl/cafe_pkg.sv
// Shared codes for the cafe order arbiter: brewing-machine state codes and
// the arbiter FSM state encoding.
package cafe_pkg;

  typedef enum logic [3:0] {
    MS_IDLE              = 4'd1,
    MS_STEP_2            = 4'd2,
    MS_STEP_3            = 4'd3,
    MS_STEP_4            = 4'd4,
    MS_STEP_5            = 4'd5,
    MS_STEP_6            = 4'd6,
    MS_STEP_7            = 4'd7,
    MS_STEP_8            = 4'd8,
    MS_REALIZAR_EXTRACAO = 4'd9
  } mach_code_e;

  typedef enum logic [2:0] {
    A_IDLE  = 3'd0,
    A_START = 3'd1,
    A_WAIT  = 3'd2,
    A_DONE  = 3'd3,
    A_FAULT = 3'd4
  } arb_state_e;

endpackage

// File: rtl/cafe_order_arbiter_rr_picker.sv
// Combinational round-robin search: first pending bit at or above ptr,
// wrapping around, returned one-hot.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic             any
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!found && pending[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any = |pending;

endmodule

// File: rtl/cafe_order_arbiter.sv
// Order arbiter for a shared brewing machine: round-robin service of N_REQ
// requesters, per-phase timeout and a sticky fault cleared by clear_fault.
//
// state   | meaning
// A_IDLE  | waiting for a pending order and an idle machine
// A_START | start asserted, waiting for the machine to leave IDLE
// A_WAIT  | brewing, waiting for REALIZAR_EXTRACAO
// A_DONE  | one-cycle done pulse to the served requester
// A_FAULT | phase timed out, held until clear_fault
module cafe_order_arbiter
  import cafe_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [3:0]       mach_state,
  input  logic             clear_fault,
  output logic             start,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       arb_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e       state;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] winner;
  logic             any;
  logic             take;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    ptr_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_picker (
    .pending (pending),
    .ptr     (ptr),
    .winner  (winner),
    .any     (any)
  );

  assign take = (state == A_IDLE) && any && (mach_state == MS_IDLE);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) win_idx = PW'(i);
    end
  end

  assign ptr_next = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
  assign cnt_inc  = cnt + CW'(1);

  assign start     = (state == A_START);
  assign busy      = (state != A_IDLE);
  assign arb_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= A_IDLE;
      pending <= '0;
      ptr     <= '0;
      cnt     <= '0;
      grant   <= '0;
      done    <= '0;
      fault   <= 1'b0;
    end else begin
      // A new request wins over the clear of the order just granted.
      pending <= (pending & ~(take ? winner : '0)) | req;
      done    <= '0;
      case (state)
        A_IDLE: begin
          if (take) begin
            state <= A_START;
            grant <= winner;
            ptr   <= ptr_next;
            cnt   <= '0;
          end
        end
        A_START: begin
          if (mach_state != MS_IDLE) begin
            state <= A_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CW'(TIMEOUT)) begin
              state <= A_FAULT;
              grant <= '0;
              fault <= 1'b1;
            end
          end
        end
        A_WAIT: begin
          if (mach_state == MS_REALIZAR_EXTRACAO) begin
            state <= A_DONE;
            done  <= grant;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CW'(TIMEOUT)) begin
              state <= A_FAULT;
              grant <= '0;
              fault <= 1'b1;
            end
          end
        end
        A_DONE: begin
          state <= A_IDLE;
          grant <= '0;
        end
        A_FAULT: begin
          if (clear_fault) begin
            state <= A_IDLE;
            fault <= 1'b0;
          end
        end
        default: state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cafe_order_arbiter.sv
// Self-checking bench for cafe_order_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a queue-level reference model.
module tb_cafe_order_arbiter;
  import cafe_pkg::*;

  localparam int N  = 4;
  localparam int TO = 31;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [3:0]   mach_state;
  logic         clear_fault;
  logic         start;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         busy;
  logic         fault;
  logic [2:0]   arb_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cafe_order_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .mach_state  (mach_state),
    .clear_fault (clear_fault),
    .start       (start),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .fault       (fault),
    .arb_state   (arb_state)
  );

  // reference model state
  arb_state_e   m_st;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_done;
  int           m_ptr;
  int           m_cnt;
  int           m_grant;
  logic         m_fault;

  logic [N-1:0] grant_log[$];
  logic [N-1:0] done_log[$];
  logic [N-1:0] prev_grant;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = A_IDLE; m_pend = '0; m_done = '0;
    m_ptr = 0; m_cnt = 0; m_grant = -1; m_fault = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] ms, input logic [N-1:0] r, input logic cf);
    int win;
    win = -1;
    m_done = '0;
    case (m_st)
      A_IDLE: begin
        if (m_pend != '0 && ms == 4'd1) begin
          for (int k = 0; k < N; k++)
            if (win < 0 && ((m_pend >> ((m_ptr + k) % N)) & N'(1)) != '0) win = (m_ptr + k) % N;
          m_grant = win; m_ptr = (win + 1) % N; m_cnt = 0; m_st = A_START;
        end
      end
      A_START: begin
        if (ms != 4'd1) begin
          m_st = A_WAIT; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == TO) begin m_st = A_FAULT; m_grant = -1; m_fault = 1'b1; end
        end
      end
      A_WAIT: begin
        if (ms == 4'd9) begin
          m_st = A_DONE; m_done = N'(1) << m_grant;
        end else begin
          m_cnt++;
          if (m_cnt == TO) begin m_st = A_FAULT; m_grant = -1; m_fault = 1'b1; end
        end
      end
      A_DONE: begin m_st = A_IDLE; m_grant = -1; end
      A_FAULT: if (cf) begin m_st = A_IDLE; m_fault = 1'b0; end
      default: m_st = A_IDLE;
    endcase
    if (win >= 0) m_pend = m_pend & ~(N'(1) << win);
    m_pend = m_pend | r;
  endtask

  task automatic compare_model();
    logic [N-1:0] g;
    g = (m_grant < 0) ? '0 : (N'(1) << m_grant);
    check("grant", 32'(grant), 32'(g));
    check("done", 32'(done), 32'(m_done));
    check("start", 32'(start), 32'(m_st == A_START));
    check("busy", 32'(busy), 32'(m_st != A_IDLE));
    check("fault", 32'(fault), 32'(m_fault));
    check("arb_state", 32'(arb_state), 32'(m_st));
  endtask

  task automatic cycle(input logic [3:0] ms, input logic [N-1:0] r, input logic cf);
    @(negedge clk);
    mach_state = ms; req = r; clear_fault = cf;
    @(posedge clk);
    model_step(ms, r, cf);
    #1;
    compare_model();
    if (grant != prev_grant && grant != '0) grant_log.push_back(grant);
    prev_grant = grant;
    if (done != '0) done_log.push_back(done);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; mach_state = 4'd1; clear_fault = 1'b0;
    #1;
    model_reset();
    compare_model();
    @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete(); done_log.delete(); prev_grant = '0;
  endtask

  task automatic serve_one();
    cycle(4'd1, '0, 1'b0);
    cycle(4'd2, '0, 1'b0);
    cycle(4'd6, '0, 1'b0);
    cycle(4'd9, '0, 1'b0);
    cycle(4'd1, '0, 1'b0);
  endtask

  logic [3:0] seq_ms[10] = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
  logic [N-1:0] exp_rr[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    int stuck_left;
    logic [3:0] stuck_val;
    logic [3:0] ms;
    logic [N-1:0] r;
    int sel;

    rst_n = 1'b0; req = '0; mach_state = 4'd1; clear_fault = 1'b0;
    prev_grant = '0;
    model_reset();

    // reset state
    do_reset();
    check("reset_start", 32'(start), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);

    // single order with latency
    cycle(4'd1, 4'b0001, 1'b0);
    check("single_no_grant_yet", 32'(grant), 32'd0);
    cycle(4'd1, '0, 1'b0);
    check("single_start", 32'(start), 32'd1);
    check("single_grant", 32'(grant), 32'b0001);
    for (int i = 0; i < 10; i++) begin
      cycle(seq_ms[i], '0, 1'b0);
      if (i == 0) check("single_start_drop", 32'(start), 32'd0);
      if (i == 8) check("single_done", 32'(done), 32'b0001);
    end
    check("single_idle", 32'(busy), 32'd0);
    check("single_done_count", 32'(done_log.size()), 32'd1);

    // contention
    do_reset();
    cycle(4'd1, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) serve_one();
    check("contend_grants", 32'(grant_log.size()), 32'd4);
    check("contend_dones", 32'(done_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) check("contend_order", 32'(grant_log[i]), 32'(exp_rr[i]));

    // fairness: serve requester 1 so the pointer sits at 2
    do_reset();
    cycle(4'd1, 4'b0010, 1'b0);
    serve_one();
    cycle(4'd1, 4'b0101, 1'b0);
    grant_log.delete();
    serve_one();
    serve_one();
    check("fair_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("fair_first", 32'(grant_log[0]), 32'b0100);
      check("fair_second", 32'(grant_log[1]), 32'b0001);
    end

    // stuck machine in START, then in WAIT
    do_reset();
    cycle(4'd1, 4'b0011, 1'b0);
    cycle(4'd1, '0, 1'b0);
    for (int i = 0; i < TO - 1; i++) cycle(4'd1, '0, 1'b0);
    check("stuck_still_start", 32'(arb_state), 32'(A_START));
    cycle(4'd1, '0, 1'b0);
    check("stuck_fault", 32'(fault), 32'd1);
    check("stuck_grant", 32'(grant), 32'd0);
    cycle(4'd1, 4'b0001, 1'b0);
    check("fault_hold", 32'(arb_state), 32'(A_FAULT));
    cycle(4'd1, '0, 1'b1);
    check("fault_cleared", 32'(fault), 32'd0);
    cycle(4'd1, '0, 1'b0);
    check("retained_grant", 32'(grant), 32'b0010);
    cycle(4'd2, '0, 1'b0);
    for (int i = 0; i < TO - 1; i++) cycle(4'd5, '0, 1'b0);
    check("wait_still", 32'(arb_state), 32'(A_WAIT));
    cycle(4'd5, '0, 1'b0);
    check("wait_fault", 32'(fault), 32'd1);
    cycle(4'd1, '0, 1'b1);
    cycle(4'd1, '0, 1'b1);
    check("cf_ignored_idle", 32'(grant), 32'b0001);

    // re-order during WAIT
    do_reset();
    cycle(4'd1, 4'b0010, 1'b0);
    cycle(4'd1, '0, 1'b0);
    cycle(4'd2, '0, 1'b0);
    cycle(4'd5, 4'b0010, 1'b0);
    cycle(4'd9, '0, 1'b0);
    cycle(4'd1, '0, 1'b0);
    serve_one();
    check("reorder_dones", 32'(done_log.size()), 32'd2);
    if (done_log.size() == 2) check("reorder_second", 32'(done_log[1]), 32'b0010);

    // asynchronous reset while brewing
    do_reset();
    cycle(4'd1, 4'b0001, 1'b0);
    cycle(4'd1, '0, 1'b0);
    cycle(4'd2, '0, 1'b0);
    check("pre_reset_wait", 32'(arb_state), 32'(A_WAIT));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_grant", 32'(grant), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_start", 32'(start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_log.delete();
    cycle(4'd9, '0, 1'b0);
    cycle(4'd1, '0, 1'b0);
    cycle(4'd9, '0, 1'b0);
    check("no_done_after_reset", 32'(done_log.size()), 32'd0);

    // randomized traffic
    do_reset();
    stuck_left = 0;
    stuck_val  = 4'd1;
    for (int c = 0; c < 4000; c++) begin
      if (stuck_left == 0 && $urandom_range(0, 299) == 0) begin
        stuck_left = 40;
        stuck_val  = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd5;
      end
      if (stuck_left > 0) begin
        ms = stuck_val;
        stuck_left--;
      end else begin
        sel = int'($urandom_range(0, 9));
        if (sel < 4) ms = 4'd1;
        else if (sel < 6) ms = 4'd9;
        else ms = 4'($urandom_range(2, 8));
      end
      r = '0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r = r | (N'(1) << b);
      cycle(ms, r, ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
